// File: rtl/mul_div_unit_if.sv
// E-stage handshake and result bus between the pipeline and the multiply/divide unit.
// The pipeline side is the master and the unit is the slave.
interface mul_div_unit_if;
  logic [3:0]  mdu_op;
  logic        start;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        req;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] mdu_out;

  modport master (
    output mdu_op, start, src_a, src_b, req,
    input  busy, hi, lo, mdu_out
  );

  modport slave (
    input  mdu_op, start, src_a, src_b, req,
    output busy, hi, lo, mdu_out
  );
endinterface

// File: rtl/mul_div_unit.sv
// Multi-cycle HI/LO multiply/divide unit: fixed-latency mult/div on latched operands,
// plus single-cycle mthi/mtlo writes and combinational mfhi/mflo read-out.
module mul_div_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic          clk,
  input  logic          reset,
  mul_div_unit_if.slave bus
);

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  localparam logic [3:0] OpMfhi = 4'b0100;
  localparam logic [3:0] OpMthi = 4'b0110;
  localparam logic [3:0] OpMtlo = 4'b0111;

  typedef enum logic {StIdle, StBusy} state_e;

  state_e          r_state, w_state_next;
  logic [CntW-1:0] r_cnt, w_cnt_next;
  logic [3:0]      r_op, w_op_next;
  logic [31:0]     r_a, w_a_next;
  logic [31:0]     r_b, w_b_next;
  logic [31:0]     r_hi, w_hi_next;
  logic [31:0]     r_lo, w_lo_next;

  logic        w_idle_ok;
  logic        w_accept;
  logic        w_signed;
  logic        w_is_div;
  logic [63:0] w_mul_a;
  logic [63:0] w_mul_b;
  logic [63:0] w_prod;
  logic        w_a_neg;
  logic        w_b_neg;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic        w_div_zero;
  logic [31:0] w_den;
  logic [31:0] w_q_mag;
  logic [31:0] w_r_mag;
  logic [31:0] w_quot;
  logic [31:0] w_rem;

  assign w_idle_ok = (r_state == StIdle) && !bus.req;
  assign w_accept  = w_idle_ok && bus.start && (bus.mdu_op[3:2] == 2'b00);

  // Latched op: bit 1 selects divide, bit 0 selects unsigned.
  assign w_signed = ~r_op[0];
  assign w_is_div = r_op[1];

  // Sign-extending to 64 bits makes the low 64 bits of the product the signed result.
  assign w_mul_a = {{32{w_signed & r_a[31]}}, r_a};
  assign w_mul_b = {{32{w_signed & r_b[31]}}, r_b};
  assign w_prod  = w_mul_a * w_mul_b;

  // Signed divide via magnitudes; 0x80000000 / -1 naturally wraps to 0x80000000 rem 0.
  assign w_a_neg    = w_signed & r_a[31];
  assign w_b_neg    = w_signed & r_b[31];
  assign w_a_mag    = w_a_neg ? (32'd0 - r_a) : r_a;
  assign w_b_mag    = w_b_neg ? (32'd0 - r_b) : r_b;
  assign w_div_zero = (r_b == 32'd0);
  assign w_den      = w_div_zero ? 32'd1 : w_b_mag;
  assign w_q_mag    = w_a_mag / w_den;
  assign w_r_mag    = w_a_mag % w_den;
  assign w_quot     = (w_a_neg ^ w_b_neg) ? (32'd0 - w_q_mag) : w_q_mag;
  assign w_rem      = w_a_neg ? (32'd0 - w_r_mag) : w_r_mag;

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_op_next    = r_op;
    w_a_next     = r_a;
    w_b_next     = r_b;
    w_hi_next    = r_hi;
    w_lo_next    = r_lo;
    unique case (r_state)
      StIdle: begin
        if (w_accept) begin
          w_state_next = StBusy;
          w_op_next    = bus.mdu_op;
          w_a_next     = bus.src_a;
          w_b_next     = bus.src_b;
          w_cnt_next   = bus.mdu_op[1] ? CntW'(DIV_CYCLES) : CntW'(MULT_CYCLES);
        end else if (w_idle_ok && (bus.mdu_op == OpMthi)) begin
          w_hi_next = bus.src_a;
        end else if (w_idle_ok && (bus.mdu_op == OpMtlo)) begin
          w_lo_next = bus.src_a;
        end
      end
      StBusy: begin
        if (r_cnt <= CntW'(1)) begin
          w_state_next = StIdle;
          w_cnt_next   = '0;
          if (!w_is_div) begin
            w_hi_next = w_prod[63:32];
            w_lo_next = w_prod[31:0];
          end else if (!w_div_zero) begin
            w_hi_next = w_rem;
            w_lo_next = w_quot;
          end
        end else begin
          w_cnt_next = r_cnt - CntW'(1);
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_op    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_op    <= w_op_next;
      r_a     <= w_a_next;
      r_b     <= w_b_next;
      r_hi    <= w_hi_next;
      r_lo    <= w_lo_next;
    end
  end

  assign bus.busy    = (r_state == StBusy);
  assign bus.hi      = r_hi;
  assign bus.lo      = r_lo;
  assign bus.mdu_out = (bus.mdu_op == OpMfhi) ? r_hi : r_lo;

endmodule

// File: tb/tb_mul_div_unit.sv
// Bench for mul_div_unit: directed cases with literal expectations, then random traffic
// checked every cycle against an arithmetic reference model.
module tb_mul_div_unit;

  localparam int unsigned MulN = 5;
  localparam int unsigned DivN = 10;

  logic clk;
  logic reset;
  mul_div_unit_if bus ();

  mul_div_unit #(
    .MULT_CYCLES(MulN),
    .DIV_CYCLES (DivN)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total;
  int bad;
  logic chk_en;

  typedef struct packed {
    logic        commit;
    logic [31:0] hi;
    logic [31:0] lo;
  } res_t;

  logic [31:0] m_hi;
  logic [31:0] m_lo;
  int          m_left;
  res_t        m_pend;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h want %08h", name, act, exp);
    end
  endtask

  function automatic res_t model_op(input logic [3:0] op, input logic [31:0] a,
                                    input logic [31:0] b);
    res_t        r;
    longint      sa;
    longint      sb;
    longint      q;
    longint      m;
    logic [63:0] p;
    r = '0;
    case (op)
      4'd0: begin
        sa = $signed(a);
        sb = $signed(b);
        p  = sa * sb;
        r  = {1'b1, p[63:32], p[31:0]};
      end
      4'd1: begin
        p = {32'd0, a} * {32'd0, b};
        r = {1'b1, p[63:32], p[31:0]};
      end
      4'd2, 4'd3: begin
        if (b != 32'd0) begin
          if (op == 4'd2) begin
            sa = $signed(a);
            sb = $signed(b);
          end else begin
            sa = {32'd0, a};
            sb = {32'd0, b};
          end
          q = sa / sb;
          m = sa % sb;
          r = {1'b1, m[31:0], q[31:0]};
        end
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  // Reference model: pending result lands when the remaining busy count runs out.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_hi   <= '0;
      m_lo   <= '0;
      m_left <= 0;
      m_pend <= '0;
    end else if (m_left != 0) begin
      m_left <= m_left - 1;
      if (m_left == 1 && m_pend.commit) begin
        m_hi <= m_pend.hi;
        m_lo <= m_pend.lo;
      end
    end else if (!bus.req) begin
      if (bus.start && (bus.mdu_op inside {4'd0, 4'd1, 4'd2, 4'd3})) begin
        m_pend <= model_op(bus.mdu_op, bus.src_a, bus.src_b);
        m_left <= (bus.mdu_op inside {4'd2, 4'd3}) ? DivN : MulN;
      end else if (bus.mdu_op == 4'd6) begin
        m_hi <= bus.src_a;
      end else if (bus.mdu_op == 4'd7) begin
        m_lo <= bus.src_a;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_busy", {31'd0, bus.busy}, {31'd0, (m_left != 0)});
      check("cyc_hi", bus.hi, m_hi);
      check("cyc_lo", bus.lo, m_lo);
      check("cyc_out", bus.mdu_out, (bus.mdu_op == 4'd4) ? m_hi : m_lo);
    end
  end

  task automatic set_idle();
    bus.mdu_op = 4'hF;
    bus.start  = 1'b0;
    bus.src_a  = '0;
    bus.src_b  = '0;
    bus.req    = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic st, input logic [31:0] a,
                       input logic [31:0] b, input logic rq);
    bus.mdu_op = op;
    bus.start  = st;
    bus.src_a  = a;
    bus.src_b  = b;
    bus.req    = rq;
    tick();
    set_idle();
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (bus.busy === 1'b1 && n < 200) begin
      n++;
      tick();
    end
  endtask

  task automatic run_md(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int n);
    issue(op, 1'b1, a, b, 1'b0);
    wait_idle(n);
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      5:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int n;
    logic [3:0] op;
    total  = 0;
    bad    = 0;
    chk_en = 1'b0;
    set_idle();
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    chk_en = 1'b1;
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_hi", bus.hi, 32'd0);
    check("rst_lo", bus.lo, 32'd0);

    run_md(4'd0, 32'hFFFF_FFFF, 32'h0000_0002, n);
    check("mult_cycles", 32'(n), 32'd5);
    check("mult_hi", bus.hi, 32'hFFFF_FFFF);
    check("mult_lo", bus.lo, 32'hFFFF_FFFE);
    check("model_mult_hi", m_hi, 32'hFFFF_FFFF);

    run_md(4'd1, 32'hFFFF_FFFF, 32'h0000_0002, n);
    check("multu_cycles", 32'(n), 32'd5);
    check("multu_hi", bus.hi, 32'h0000_0001);
    check("multu_lo", bus.lo, 32'hFFFF_FFFE);

    run_md(4'd2, 32'hFFFF_FFF9, 32'h0000_0002, n);
    check("div_cycles", 32'(n), 32'd10);
    check("div_lo", bus.lo, 32'hFFFF_FFFD);
    check("div_hi", bus.hi, 32'hFFFF_FFFF);
    check("model_div_lo", m_lo, 32'hFFFF_FFFD);

    issue(4'd6, 1'b0, 32'h1234_5678, 32'd0, 1'b0);
    check("mthi_hi", bus.hi, 32'h1234_5678);
    check("mthi_busy", {31'd0, bus.busy}, 32'd0);
    run_md(4'd3, 32'h0000_0007, 32'd0, n);
    check("divz_cycles", 32'(n), 32'd10);
    check("divz_hi", bus.hi, 32'h1234_5678);
    check("divz_lo", bus.lo, 32'hFFFF_FFFD);

    run_md(4'd2, 32'h8000_0000, 32'hFFFF_FFFF, n);
    check("ovf_lo", bus.lo, 32'h8000_0000);
    check("ovf_hi", bus.hi, 32'h0000_0000);
    check("model_ovf_lo", m_lo, 32'h8000_0000);

    issue(4'd0, 1'b1, 32'd5, 32'd5, 1'b1);
    check("reqstart_busy", {31'd0, bus.busy}, 32'd0);
    check("reqstart_hi", bus.hi, 32'h0000_0000);
    issue(4'd7, 1'b0, 32'hDEAD_BEEF, 32'd0, 1'b1);
    check("reqmtlo_lo", bus.lo, 32'h8000_0000);

    issue(4'd4, 1'b1, 32'd3, 32'd3, 1'b0);
    check("badop_busy", {31'd0, bus.busy}, 32'd0);

    issue(4'd6, 1'b0, 32'hAAAA_5555, 32'd0, 1'b0);
    issue(4'd7, 1'b0, 32'h1234_ABCD, 32'd0, 1'b0);
    bus.mdu_op = 4'd4;
    #1 check("mfhi_out", bus.mdu_out, 32'hAAAA_5555);
    bus.mdu_op = 4'd5;
    #1 check("mflo_out", bus.mdu_out, 32'h1234_ABCD);
    bus.mdu_op = 4'hF;
    #1 check("none_out", bus.mdu_out, 32'h1234_ABCD);
    bus.mdu_op = 4'hA;
    #1 check("other_out", bus.mdu_out, 32'h1234_ABCD);
    set_idle();
    tick();

    issue(4'd0, 1'b1, 32'd3, 32'd4, 1'b0);
    tick();
    tick();
    issue(4'd0, 1'b1, 32'd9, 32'd9, 1'b1);
    wait_idle(n);
    check("req_mid_tail", 32'(n), 32'd2);
    check("req_mid_lo", bus.lo, 32'd12);
    check("req_mid_hi", bus.hi, 32'd0);

    issue(4'd0, 1'b1, 32'd6, 32'd7, 1'b0);
    tick();
    issue(4'd2, 1'b1, 32'd100, 32'd3, 1'b0);
    wait_idle(n);
    check("second_tail", 32'(n), 32'd3);
    check("second_lo", bus.lo, 32'd42);
    check("second_hi", bus.hi, 32'd0);
    tick();
    check("second_busy", {31'd0, bus.busy}, 32'd0);

    issue(4'd6, 1'b0, 32'h0000_0055, 32'd0, 1'b0);
    issue(4'd2, 1'b1, 32'd100, 32'd7, 1'b0);
    tick();
    tick();
    tick();
    #2 reset = 1'b1;
    #1;
    check("rstbusy_busy", {31'd0, bus.busy}, 32'd0);
    check("rstbusy_hi", bus.hi, 32'd0);
    check("rstbusy_lo", bus.lo, 32'd0);
    #2 reset = 1'b0;
    repeat (10) tick();
    check("rstafter_busy", {31'd0, bus.busy}, 32'd0);
    check("rstafter_hi", bus.hi, 32'd0);
    check("rstafter_lo", bus.lo, 32'd0);

    run_md(4'd1, 32'h0001_0000, 32'h0001_0000, n);
    check("post_rst_cycles", 32'(n), 32'd5);
    check("post_rst_hi", bus.hi, 32'h0000_0001);

    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: op = 4'($urandom_range(0, 3));
        4:          op = 4'd4;
        5:          op = 4'd5;
        6:          op = 4'd6;
        7:          op = 4'd7;
        8:          op = 4'hF;
        default:    op = 4'($urandom_range(8, 14));
      endcase
      bus.mdu_op = op;
      bus.start  = (op <= 4'd3) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0);
      bus.req    = ($urandom_range(0, 7) == 0);
      bus.src_a  = rand_operand();
      bus.src_b  = rand_operand();
      if ($urandom_range(0, 99) == 0) begin
        #2 reset = 1'b1;
        #1 reset = 1'b0;
      end
      tick();
    end
    set_idle();
    repeat (12) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 Parameter MULT_CYCLES, default 5, busy duration in cycles for mult/multu.
REQ-002 Parameter DIV_CYCLES, default 10, busy duration in cycles for div/divu.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high; clears all state immediately, independent of clk.
REQ-005 mdu_op  input  4  E-stage op: 0000 mult, 0001 multu, 0010 div, 0011 divu, 0100 mfhi, 0101 mflo, 0110 mthi, 0111 mtlo, 1111 none; other codes treated as none.
REQ-006 start  input  1  E-stage instruction is mult/multu/div/divu.
REQ-007 src_a  input  32  forwarded rs value: dividend, multiplicand, or mthi/mtlo data.
REQ-008 src_b  input  32  forwarded rt value: divisor or multiplier.
REQ-009 req  input  1  exception/interrupt flush of the current E-stage instruction.
REQ-010 busy  output  1  multi-cycle operation in progress.
REQ-011 hi  output  32  architectural HI register.
REQ-012 lo  output  32  architectural LO register.
REQ-013 mdu_out  output  32  read data: hi when mdu_op=0100, else lo.

Function
REQ-014 Two states, IDLE and BUSY, plus a down-counter; busy=1 exactly when state is BUSY.
REQ-015 Accept: start=1, req=0, state IDLE, mdu_op in {0000..0011} -> at that edge latch op, src_a, src_b; load counter with MULT_CYCLES or DIV_CYCLES; enter BUSY.
REQ-016 Accept at edge ending cycle T -> busy=1 in cycles T+1..T+N; at edge ending T+N, hi/lo written and state returns to IDLE; busy=0 and new hi/lo visible in T+N+1.
REQ-017 mult: {hi,lo} = signed 64-bit product of latched operands; multu: unsigned 64-bit product.
REQ-018 div: lo = signed quotient truncated toward zero, hi = remainder with sign of dividend; divu: unsigned quotient/remainder.
REQ-019 Signed 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0x00000000.
REQ-020 Divisor zero (div or divu) -> full DIV_CYCLES busy period, hi and lo unchanged at completion.
REQ-021 Results are computed from latched operands only; src_a/src_b changes during BUSY have no effect.
REQ-022 mthi (0110) with req=0 and state IDLE -> hi=src_a at that edge; mtlo (0111) likewise writes lo; no busy period.
REQ-023 req=1 -> start, mthi and mtlo in that cycle ignored; no state change.
REQ-024 req=1 during BUSY does not cancel the operation in flight; it completes normally.
REQ-025 start, mthi or mtlo while BUSY -> ignored; upstream stall logic (stall when the D-stage op is an MDU op and start|busy) prevents this.
REQ-026 start=1 with mdu_op outside {0000..0011} -> ignored.
REQ-027 mdu_out combinational from mdu_op, hi, lo; mfhi/mflo read the committed value and are valid only when busy=0 and start=0 (guaranteed by stall).
REQ-028 hi/lo change only on completion (REQ-016), mthi/mtlo (REQ-022), or reset.

Reset
REQ-029 reset=1 -> state IDLE, counter 0, busy=0, hi=0, lo=0, latched operands 0, asynchronously.
REQ-030 Reset during BUSY aborts the operation; no result written after reset deasserts.
REQ-031 First accepted start after reset deassertion behaves per REQ-015/016.

Verification
REQ-032 mult src_a=0xFFFFFFFF, src_b=0x00000002 -> busy 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFE.
REQ-033 multu same operands -> busy 5 cycles, then hi=0x00000001, lo=0xFFFFFFFE.
REQ-034 div src_a=0xFFFFFFF9 (-7), src_b=0x00000002 -> busy 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF; divu 0x00000007/0 after mthi 0x12345678 -> busy 10 cycles, hi stays 0x12345678.
REQ-035 start=1 with req=1 -> busy stays 0, hi/lo unchanged; mtlo 0xDEADBEEF with req=1 -> lo unchanged; req=1 in 3rd busy cycle of mult -> result still committed after cycle 5.
REQ-036 reset asserted in 4th busy cycle of div -> busy=0, hi=lo=0 immediately and still 0 after 10 further cycles.
REQ-037 mdu_op=0100 -> mdu_out=hi; mdu_op=0101 or 1111 -> mdu_out=lo; second start during BUSY -> ignored, first result unaffected.
